tile_map_writer: RTL and testbench

Write side of the 848×480, 2-bit-per-pixel frame map consumed by the VGA line display. Game logic (snake/pong) issues tile-draw and screen-fill commands over a valid/ready handshake; the block stores a 53×30 tile map (16×16-pixel tiles) and serves the display's per-line read requests by expanding one tile row into a full 1696-bit pixel line. It replaces the static map source feeding the display's line buffer.

---
 rtl/tile_map_writer_pkg.sv | 46 ++++
 rtl/tile_map_writer_expand.sv | 15 +
 rtl/tile_map_writer.sv | 147 ++++++++++++++
 tb/tb_tile_map_writer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_map_writer_pkg.sv
// Shared constants, encodings and command payload for the tile map writer.
package tile_map_writer_pkg;

    localparam int unsigned TILE_SHIFT  = 4;
    localparam int unsigned TILE_PIX    = 1 << TILE_SHIFT;
    localparam int unsigned COLS        = 53;
    localparam int unsigned ROWS        = 30;
    localparam int unsigned LINE_PIXELS = 848;
    localparam int unsigned LINE_ROWS   = ROWS * TILE_PIX;
    localparam int unsigned COLOR_W     = 2;
    localparam int unsigned ROW_BITS    = COLOR_W * COLS;
    localparam int unsigned LINE_BITS   = COLOR_W * LINE_PIXELS;
    localparam int unsigned X_W         = 6;
    localparam int unsigned Y_W         = 5;
    localparam int unsigned LROW_W      = 9;

    typedef enum logic [1:0] {
        COLOR_BLACK = 2'd0,
        COLOR_RED   = 2'd1,
        COLOR_GREEN = 2'd2,
        COLOR_BLUE  = 2'd3
    } color_e;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_FILL  = 1'b1
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
    } tile_cmd_t;

    // True when the tile coordinate lies inside the map.
    function automatic logic tile_in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (x < X_W'(COLS)) && (y < Y_W'(ROWS));
    endfunction

endpackage

// File: rtl/tile_map_writer_expand.sv
// Combinational expansion of one tile row into a full pixel line.
module tile_row_expand
    import tile_map_writer_pkg::*;
(
    input  logic [ROW_BITS-1:0]  i_row,
    output logic [LINE_BITS-1:0] o_line_c
);

    localparam int unsigned TILE_BITS = TILE_PIX * COLOR_W;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        assign o_line_c[c*TILE_BITS +: TILE_BITS] = {TILE_PIX{i_row[c*COLOR_W +: COLOR_W]}};
    end

endmodule

// File: rtl/tile_map_writer.sv
// Tile map store: accepts tile write / map fill commands and serves expanded pixel lines.
module tile_map_writer
    import tile_map_writer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready_c,
    input  logic                 i_cmd_op,
    input  logic [X_W-1:0]       i_cmd_x,
    input  logic [Y_W-1:0]       i_cmd_y,
    input  logic [COLOR_W-1:0]   i_cmd_color,
    output logic                 o_cmd_err,
    output logic                 o_busy,
    input  logic                 i_line_req,
    input  logic [LROW_W-1:0]    i_line_row,
    output logic [LINE_BITS-1:0] o_line_data,
    output logic                 o_line_valid
);

    state_e                r_state;
    state_e                w_state_nxt;
    tile_cmd_t             r_cmd;
    logic [Y_W-1:0]        r_row_cnt;
    logic [ROW_BITS-1:0]   r_map [ROWS];
    logic                  r_cmd_err;
    logic                  r_busy;
    logic [LINE_BITS-1:0]  r_line_data;
    logic                  r_line_valid;

    logic                  w_accept;
    logic                  w_cmd_err_nxt;
    logic                  w_tile_wr;
    logic                  w_row_wr;
    logic                  w_fill_last;
    logic                  w_line_ok;
    logic [Y_W-1:0]        w_tile_row;
    logic [ROW_BITS-1:0]   w_row_bits;
    logic [LINE_BITS-1:0]  w_line;

    assign o_cmd_ready_c = (r_state == ST_IDLE);
    assign w_fill_last   = (r_row_cnt == Y_W'(ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_cmd_err_nxt = 1'b0;
        w_tile_wr     = 1'b0;
        w_row_wr      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    w_accept = 1'b1;
                    if (i_cmd_op == OP_FILL) begin
                        w_state_nxt = ST_FILL;
                    end else begin
                        w_state_nxt   = ST_WRITE;
                        w_cmd_err_nxt = !tile_in_range(i_cmd_x, i_cmd_y);
                    end
                end
            end
            ST_WRITE: begin
                w_tile_wr   = tile_in_range(r_cmd.x, r_cmd.y);
                w_state_nxt = ST_IDLE;
            end
            ST_FILL: begin
                w_row_wr = 1'b1;
                if (w_fill_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Command latch, fill row counter and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd     <= '0;
            r_row_cnt <= '0;
            r_cmd_err <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_cmd_err <= w_cmd_err_nxt;
            r_busy    <= (w_state_nxt == ST_FILL);
            if (w_accept) begin
                r_cmd.color <= i_cmd_color;
                if (i_cmd_op == OP_FILL) begin
                    r_row_cnt <= '0;
                end else begin
                    r_cmd.x <= i_cmd_x;
                    r_cmd.y <= i_cmd_y;
                end
            end else if (w_row_wr) begin
                r_row_cnt <= w_fill_last ? '0 : r_row_cnt + Y_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                r_map[i] <= '0;
            end
        end else if (w_row_wr) begin
            r_map[r_row_cnt] <= {COLS{r_cmd.color}};
        end else if (w_tile_wr) begin
            r_map[r_cmd.y][{r_cmd.x, 1'b0} +: COLOR_W] <= r_cmd.color;
        end
    end

    // Read port: rows past the visible area return black.
    assign w_line_ok  = (i_line_row < LROW_W'(LINE_ROWS));
    assign w_tile_row = Y_W'(i_line_row >> TILE_SHIFT);
    assign w_row_bits = w_line_ok ? r_map[w_tile_row] : '0;

    tile_row_expand u_expand (
        .i_row    (w_row_bits),
        .o_line_c (w_line)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_data  <= '0;
            r_line_valid <= 1'b0;
        end else begin
            r_line_valid <= i_line_req;
            if (i_line_req) begin
                r_line_data <= w_line;
            end
        end
    end

    assign o_cmd_err    = r_cmd_err;
    assign o_busy       = r_busy;
    assign o_line_data  = r_line_data;
    assign o_line_valid = r_line_valid;

endmodule

// File: tb/tb_tile_map_writer.sv
// Scoreboard bench for tile_map_writer: directed commands, expected lines queued and checked by a monitor.
module tb_tile_map_writer;

    localparam int NPIX  = 848;
    localparam int LBITS = 2 * NPIX;

    logic             clk;
    logic             rst_n;
    logic             i_cmd_valid;
    logic             o_cmd_ready_c;
    logic             i_cmd_op;
    logic [5:0]       i_cmd_x;
    logic [4:0]       i_cmd_y;
    logic [1:0]       i_cmd_color;
    logic             o_cmd_err;
    logic             o_busy;
    logic             i_line_req;
    logic [8:0]       i_line_row;
    logic [LBITS-1:0] o_line_data;
    logic             o_line_valid;

    int checks = 0;
    int errors = 0;

    logic [LBITS-1:0] exp_q [$];
    string            name_q [$];

    tile_map_writer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready_c (o_cmd_ready_c),
        .i_cmd_op      (i_cmd_op),
        .i_cmd_x       (i_cmd_x),
        .i_cmd_y       (i_cmd_y),
        .i_cmd_color   (i_cmd_color),
        .o_cmd_err     (o_cmd_err),
        .o_busy        (o_busy),
        .i_line_req    (i_line_req),
        .i_line_row    (i_line_row),
        .o_line_data   (o_line_data),
        .o_line_valid  (o_line_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1);
    end

    // Line with background colour bg and pixels lo..hi in colour fg.
    function automatic logic [LBITS-1:0] mk_line(input logic [1:0] bg, input logic [1:0] fg,
                                                 input int lo, input int hi);
        logic [LBITS-1:0] l;
        for (int p = 0; p < NPIX; p++) begin
            l[2*p +: 2] = (p >= lo && p <= hi) ? fg : bg;
        end
        return l;
    endfunction

    // Monitor: every LINE_VALID pulse consumes one expected line.
    always @(negedge clk) begin
        if (rst_n && o_line_valid) begin
            logic [LBITS-1:0] exp;
            string            nm;
            int               bad;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL line_unexpected got valid=1 exp no pending request");
            end else begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                if (o_line_data !== exp) begin
                    bad = -1;
                    for (int p = 0; p < NPIX; p++) begin
                        if (bad < 0 && o_line_data[2*p +: 2] !== exp[2*p +: 2]) bad = p;
                    end
                    errors++;
                    $display("FAIL %s pixel %0d got %b exp %b", nm, bad,
                             o_line_data[2*bad +: 2], exp[2*bad +: 2]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    task automatic line_req(input int row, input logic [LBITS-1:0] exp, input string nm);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        i_line_req = 1'b1;
        i_line_row = 9'(row);
        tick();
        i_line_req = 1'b0;
        tick();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_cmd_ready_c && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got ready=0 exp ready=1");
        end
    endtask

    task automatic issue(input logic op, input int x, input int y, input int c);
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_x     = 6'(x);
        i_cmd_y     = 5'(y);
        i_cmd_color = 2'(c);
        wait_ready();
        tick();
    endtask

    task automatic do_write(input int x, input int y, input int c, input logic exp_err, input string nm);
        issue(1'b0, x, y, c);
        i_cmd_valid = 1'b0;
        chk({nm, "_err"}, 32'(o_cmd_err), 32'(exp_err));
        chk({nm, "_ready_low"}, 32'(o_cmd_ready_c), 32'd0);
        tick();
        chk({nm, "_err_clear"}, 32'(o_cmd_err), 32'd0);
        chk({nm, "_ready_back"}, 32'(o_cmd_ready_c), 32'd1);
    endtask

    initial begin
        logic [LBITS-1:0] zero_l;
        logic [LBITS-1:0] green_l;
        zero_l  = mk_line(2'b00, 2'b00, 1, 0);
        green_l = mk_line(2'b10, 2'b10, 1, 0);

        rst_n       = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_op    = 1'b0;
        i_cmd_x     = '0;
        i_cmd_y     = '0;
        i_cmd_color = '0;
        i_line_req  = 1'b0;
        i_line_row  = '0;
        #2;
        chk("rst_ready", 32'(o_cmd_ready_c), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_err", 32'(o_cmd_err), 32'd0);
        chk("rst_valid", 32'(o_line_valid), 32'd0);
        chk("rst_data", 32'(o_line_data != '0), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(o_cmd_ready_c), 32'd1);
        line_req(0, zero_l, "rst_row0");

        do_write(2, 1, 1, 1'b0, "wr_2_1");
        line_req(16, mk_line(2'b00, 2'b01, 32, 47), "row16");
        line_req(31, mk_line(2'b00, 2'b01, 32, 47), "row31");
        line_req(15, zero_l, "row15");

        // Fill green with CMD_VALID held high for the whole fill.
        issue(1'b1, 0, 0, 2);
        for (int i = 0; i < 30; i++) begin
            chk($sformatf("fill_busy_%0d", i), 32'(o_busy), 32'd1);
            chk($sformatf("fill_ready_%0d", i), 32'(o_cmd_ready_c), 32'd0);
            tick();
        end
        chk("fill_done_busy", 32'(o_busy), 32'd0);
        chk("fill_done_ready", 32'(o_cmd_ready_c), 32'd1);
        i_cmd_valid = 1'b0;
        tick();
        chk("fill_no_reaccept_busy", 32'(o_busy), 32'd0);
        line_req(0, green_l, "fill_row0");
        line_req(240, green_l, "fill_row240");
        line_req(479, green_l, "fill_row479");

        do_write(53, 0, 3, 1'b1, "wr_x53");
        do_write(0, 30, 3, 1'b1, "wr_y30");
        line_req(0, green_l, "err_row0");
        line_req(479, green_l, "err_row479");
        line_req(500, zero_l, "row500");

        // Write commit edge coincides with the read of the same row.
        issue(1'b0, 52, 29, 3);
        i_cmd_valid = 1'b0;
        exp_q.push_back(green_l);
        name_q.push_back("coincident_row470");
        i_line_req = 1'b1;
        i_line_row = 9'd470;
        tick();
        i_line_req = 1'b0;
        tick();
        line_req(479, mk_line(2'b10, 2'b11, 832, 847), "after_row479");

        // Reset during the tenth fill cycle.
        issue(1'b1, 0, 0, 1);
        i_cmd_valid = 1'b0;
        repeat (9) tick();
        chk("mid_fill_busy", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_ready", 32'(o_cmd_ready_c), 32'd1);
        chk("mrst_busy", 32'(o_busy), 32'd0);
        chk("mrst_err", 32'(o_cmd_err), 32'd0);
        chk("mrst_valid", 32'(o_line_valid), 32'd0);
        chk("mrst_data", 32'(o_line_data != '0), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("mrst_ready_after", 32'(o_cmd_ready_c), 32'd1);
        chk("mrst_busy_after", 32'(o_busy), 32'd0);
        line_req(0, zero_l, "mrst_row0");
        line_req(479, zero_l, "mrst_row479");
        line_req(160, zero_l, "mrst_row160");

        tick();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
